// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue stage: owns the PC, fetches over REQ/ACK, issues fields.
// Optional IFU_IRQ_EN adds interrupt ports and the pending/redirect logic.
module instr_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] ILLOP_ADDR = ADDR_W'(4),
  parameter logic [ADDR_W-1:0] XADDR      = ADDR_W'(8)
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              IMEM_REQ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic              IMEM_ACK,
  input  logic [31:0]       IMEM_DATA,
  output logic              INSTR_VALID,
  input  logic              INSTR_READY,
  output logic [5:0]        OPCODE,
  output logic [4:0]        RC,
  output logic [4:0]        RA,
  output logic [4:0]        RB,
  output logic [15:0]       LITERAL,
  output logic [ADDR_W-1:0] PC_PLUS4,
  input  logic [2:0]        PCSEL,
`ifdef IFU_IRQ_EN
  input  logic              IRQ,
  output logic              IRQ_TAKEN,
  output logic [ADDR_W-1:0] XP_OUT,
`endif
  input  logic [ADDR_W-1:0] JT
);

  typedef enum logic {
    FETCH,
    ISSUE
  } state_e;

  state_e            state_q;
  logic              req_q;
  logic              valid_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc4_q;
  logic [5:0]        opcode_q;
  logic [4:0]        rc_q;
  logic [4:0]        ra_q;
  logic [4:0]        rb_q;
  logic [15:0]       lit_q;

  logic              retire;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] sel_pc_d;
  logic [ADDR_W-1:0] next_pc_d;

`ifdef IFU_IRQ_EN
  logic              pend_q;
  logic              taken_q;
  logic [ADDR_W-1:0] xp_q;
  logic              take_irq;
`endif

  assign retire = (state_q == ISSUE) && valid_q && INSTR_READY;
  assign br_off = {{(ADDR_W-18){lit_q[15]}}, lit_q, 2'b00};

  // Next PC from the decoder's select; pc4_q always holds PC+4.
  always_comb begin
    sel_pc_d = ILLOP_ADDR;
    case (PCSEL)
      3'd0:    sel_pc_d = pc4_q;
      3'd1:    sel_pc_d = pc4_q + br_off;
      3'd2:    sel_pc_d = JT & ~ADDR_W'(3);
      3'd4:    sel_pc_d = XADDR;
      default: sel_pc_d = ILLOP_ADDR;
    endcase
  end

`ifdef IFU_IRQ_EN
  assign take_irq  = retire && pend_q;
  // A pending interrupt redirects the retire to the vector.
  assign next_pc_d = take_irq ? XADDR : sel_pc_d;
`else
  assign next_pc_d = sel_pc_d;
`endif

  // Fetch/issue FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= FETCH;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      pc_q     <= RESET_ADDR;
      pc4_q    <= RESET_ADDR + ADDR_W'(4);
      opcode_q <= '0;
      rc_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      lit_q    <= '0;
`ifdef IFU_IRQ_EN
      pend_q   <= 1'b0;
      taken_q  <= 1'b0;
      xp_q     <= '0;
`endif
    end else begin
`ifdef IFU_IRQ_EN
      pend_q  <= (pend_q & ~retire) | IRQ;
      taken_q <= take_irq;
      if (take_irq) xp_q <= sel_pc_d;
`endif
      case (state_q)
        FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (IMEM_ACK) begin
            opcode_q <= IMEM_DATA[31:26];
            rc_q     <= IMEM_DATA[25:21];
            ra_q     <= IMEM_DATA[20:16];
            rb_q     <= IMEM_DATA[15:11];
            lit_q    <= IMEM_DATA[15:0];
            req_q    <= 1'b0;
            valid_q  <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (retire) begin
            pc_q    <= next_pc_d;
            pc4_q   <= next_pc_d + ADDR_W'(4);
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign IMEM_REQ    = req_q;
  assign IMEM_ADDR   = pc_q;
  assign INSTR_VALID = valid_q;
  assign OPCODE      = opcode_q;
  assign RC          = rc_q;
  assign RA          = ra_q;
  assign RB          = rb_q;
  assign LITERAL     = lit_q;
  assign PC_PLUS4    = pc4_q;
`ifdef IFU_IRQ_EN
  assign IRQ_TAKEN   = taken_q;
  assign XP_OUT      = xp_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a PC/field reference model.
// Define IFU_IRQ_EN to also cover the interrupt redirect.
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK = 1'b0;
  logic [31:0] IMEM_DATA = '0;
  logic        INSTR_VALID;
  logic        INSTR_READY = 1'b0;
  logic [5:0]  OPCODE;
  logic [4:0]  RC, RA, RB;
  logic [15:0] LITERAL;
  logic [31:0] PC_PLUS4;
  logic [2:0]  PCSEL = '0;
  logic [31:0] JT = '0;
`ifdef IFU_IRQ_EN
  logic        IRQ = 1'b0;
  logic        IRQ_TAKEN;
  logic [31:0] XP_OUT;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_pc;
  bit          irq_pend = 1'b0;

  instr_fetch_unit dut (
    .CLK(CLK), .RESET(RESET),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
    .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
    .OPCODE(OPCODE), .RC(RC), .RA(RA), .RB(RB),
    .LITERAL(LITERAL), .PC_PLUS4(PC_PLUS4),
    .PCSEL(PCSEL),
`ifdef IFU_IRQ_EN
    .IRQ(IRQ), .IRQ_TAKEN(IRQ_TAKEN), .XP_OUT(XP_OUT),
`endif
    .JT(JT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] pc,
                                           input logic [15:0] lit,
                                           input logic [2:0] sel,
                                           input logic [31:0] jt);
    int off;
    off = int'($signed(lit));
    case (sel)
      3'd0:    return pc + 32'd4;
      3'd1:    return pc + 32'd4 + 32'(off * 4);
      3'd2:    return {jt[31:2], 2'b00};
      3'd4:    return 32'h8;
      default: return 32'h4;
    endcase
  endfunction

  // One full fetch + issue + retire, checked against the model.
  task automatic xact(input logic [31:0] word, input int ack_dly,
                      input int rdy_dly, input logic [2:0] sel,
                      input logic [31:0] jt, input bit irq_pulse);
    int n;
    logic [31:0] nrm;
    n = 0;
    while (!IMEM_REQ && n < 8) begin
      tick();
      n++;
    end
    check("req_seen", 32'(IMEM_REQ), 32'd1);
    if (!IMEM_REQ) return;
    check("imem_addr", IMEM_ADDR, exp_pc);
    for (int i = 0; i < ack_dly; i++) begin
      INSTR_READY = 1'($urandom % 2);
      tick();
      check("req_hold", 32'(IMEM_REQ), 32'd1);
      check("addr_hold", IMEM_ADDR, exp_pc);
      check("no_valid", 32'(INSTR_VALID), 32'd0);
    end
    INSTR_READY = 1'b0;
    IMEM_ACK = 1'b1;
    IMEM_DATA = word;
    tick();
    IMEM_ACK = 1'b0;
    IMEM_DATA = $urandom;
    check("valid", 32'(INSTR_VALID), 32'd1);
    check("req_drop", 32'(IMEM_REQ), 32'd0);
    check("opcode", 32'(OPCODE), 32'(word[31:26]));
    check("rc", 32'(RC), 32'(word[25:21]));
    check("ra", 32'(RA), 32'(word[20:16]));
    check("rb", 32'(RB), 32'(word[15:11]));
    check("literal", 32'(LITERAL), 32'(word[15:0]));
    check("pc_plus4", PC_PLUS4, exp_pc + 32'd4);
    for (int i = 0; i < rdy_dly; i++) begin
      IMEM_ACK = 1'($urandom % 2);
      if (irq_pulse && i == 0) begin
        irq_pend = 1'b1;
`ifdef IFU_IRQ_EN
        IRQ = 1'b1;
`endif
      end
      tick();
`ifdef IFU_IRQ_EN
      IRQ = 1'b0;
`endif
      check("valid_hold", 32'(INSTR_VALID), 32'd1);
      check("fields_hold", {OPCODE, RC, RA, LITERAL},
            {word[31:16], word[15:0]});
    end
    IMEM_ACK = 1'b0;
    PCSEL = sel;
    JT = jt;
    INSTR_READY = 1'b1;
    tick();
    INSTR_READY = 1'b0;
    PCSEL = 3'($urandom);
    JT = $urandom;
    nrm = ref_next(exp_pc, word[15:0], sel, jt);
`ifdef IFU_IRQ_EN
    if (irq_pend) begin
      exp_pc = 32'h8;
      check("irq_taken", 32'(IRQ_TAKEN), 32'd1);
      check("xp_out", XP_OUT, nrm);
      irq_pend = 1'b0;
      tick();
      check("irq_taken_drop", 32'(IRQ_TAKEN), 32'd0);
    end else begin
      exp_pc = nrm;
      check("irq_idle", 32'(IRQ_TAKEN), 32'd0);
    end
`else
    irq_pend = 1'b0;
    exp_pc = nrm;
`endif
    check("retire_valid", 32'(INSTR_VALID), 32'd0);
    check("retire_req", 32'(IMEM_REQ), 32'd1);
    check("next_addr", IMEM_ADDR, exp_pc);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"}, 32'(IMEM_REQ), 32'd0);
    check({tag, "_addr"}, IMEM_ADDR, 32'h0);
    check({tag, "_valid"}, 32'(INSTR_VALID), 32'd0);
    check({tag, "_fields"}, {OPCODE, RC, RA, LITERAL}, 32'd0);
    check({tag, "_rb"}, 32'(RB), 32'd0);
    check({tag, "_pc4"}, PC_PLUS4, 32'h4);
`ifdef IFU_IRQ_EN
    check({tag, "_irqt"}, 32'(IRQ_TAKEN), 32'd0);
    check({tag, "_xp"}, XP_OUT, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] w;
    tick();
    tick();
    check_reset_state("rst");
    RESET = 1'b0;
    exp_pc = 32'h0;

    // Reset release and quick ACK, then sequential fetches with slow ACK.
    xact($urandom, 1, 0, 3'd0, 32'h0, 1'b0);
    xact($urandom, 3, 0, 3'd0, 32'h0, 1'b0);
    xact($urandom, 3, 0, 3'd0, 32'h0, 1'b0);
    check("seq_addr", IMEM_ADDR, 32'hC);

    // Branch back and register jump.
    xact($urandom, 0, 0, 3'd2, 32'h10, 1'b0);
    w = {16'h1234, 16'hFFFE};
    xact(w, 0, 1, 3'd1, 32'h0, 1'b0);
    check("branch_back", IMEM_ADDR, 32'h0C);
    xact($urandom, 0, 0, 3'd2, 32'h103, 1'b0);
    check("jump_mask", IMEM_ADDR, 32'h100);

    // Illegal op, exception vector, wrap.
    xact($urandom, 0, 0, 3'd6, 32'h0, 1'b0);
    check("illop", IMEM_ADDR, 32'h4);
    xact($urandom, 0, 0, 3'd4, 32'h0, 1'b0);
    check("xaddr", IMEM_ADDR, 32'h8);
    xact($urandom, 0, 0, 3'd2, 32'hFFFF_FFFC, 1'b0);
    xact($urandom, 0, 0, 3'd0, 32'h0, 1'b0);
    check("wrap", IMEM_ADDR, 32'h0);

    // Reset during fetch with a coincident ACK.
    xact($urandom, 0, 0, 3'd2, 32'h40, 1'b0);
    RESET = 1'b1;
    IMEM_ACK = 1'b1;
    IMEM_DATA = 32'hFFFF_FFFF;
    tick();
    IMEM_ACK = 1'b0;
    check_reset_state("midrst");
    RESET = 1'b0;
    exp_pc = 32'h0;
    xact($urandom, 0, 0, 3'd0, 32'h0, 1'b0);

`ifdef IFU_IRQ_EN
    xact($urandom, 0, 0, 3'd2, 32'h20, 1'b0);
    xact($urandom, 0, 2, 3'd0, 32'h0, 1'b1);
    check("irq_vec", IMEM_ADDR, 32'h8);
`endif

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      xact($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
           3'($urandom), $urandom, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
